// File: rtl/hdma_pkg.sv
// hdma_pkg: shared types and constants for the HDMA block-transfer engine.
//   state_e       engine sequencing states
//   REG_*         MMIO register indices (mmio_sel values)
//   MODE_*        CTRL bit-7 transfer mode encodings
package hdma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HWAIT,
    ALIGN,
    RD_ADDR,
    RD_DATA,
    WR,
    WR_WAIT
  } state_e;

  localparam logic [2:0] REG_SRC_HI = 3'd0;
  localparam logic [2:0] REG_SRC_LO = 3'd1;
  localparam logic [2:0] REG_DST_HI = 3'd2;
  localparam logic [2:0] REG_DST_LO = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;

  localparam logic MODE_GENERAL = 1'b0;
  localparam logic MODE_HBLANK  = 1'b1;

endpackage

// File: rtl/hdma_if.sv
// hdma_if: MMIO programming port and DMA master bus of the HDMA engine.
//   mmio_sel/mmio_wr/mmio_din  register select, write strobe, write data
//   mmio_dout                  combinational read data
//   dma_rd/dma_wr/dma_a        registered bus strobes and address
//   dma_din/dma_dout           bus read data (valid cycle after dma_rd) / write data
//   dma_occupy_bus             CPU locked off the bus
// Modport master is the engine side; slave is the system (CPU/bus) side.
interface hdma_if #(
  parameter int ADDR_W = 16
);
  logic [2:0]        mmio_sel;
  logic              mmio_wr;
  logic [7:0]        mmio_din;
  logic [7:0]        mmio_dout;
  logic              dma_rd;
  logic              dma_wr;
  logic [ADDR_W-1:0] dma_a;
  logic [7:0]        dma_din;
  logic [7:0]        dma_dout;
  logic              dma_occupy_bus;

  modport master (
    input  mmio_sel, mmio_wr, mmio_din, dma_din,
    output mmio_dout, dma_rd, dma_wr, dma_a, dma_dout, dma_occupy_bus
  );

  modport slave (
    output mmio_sel, mmio_wr, mmio_din, dma_din,
    input  mmio_dout, dma_rd, dma_wr, dma_a, dma_dout, dma_occupy_bus
  );
endinterface

// File: rtl/hdma_engine_edge_det.sv
// edge_det: rising-edge detector. The previous level is registered and
// compared against the live input, so rise is high in the cycle the input
// is first seen high and the consumer acts on the following clk edge.
//   clk   clock
//   rst   synchronous active-low reset
//   din   level input (hblank)
//   rise  din high now, low at the previous edge
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic din_q;

  always_ff @(posedge clk) begin
    if (!rst) din_q <= 1'b0;
    else      din_q <= din;
  end

  assign rise = din & ~din_q;
endmodule

// File: rtl/hdma_engine.sv
// hdma_engine: block-transfer engine copying 2^BLK_LOG2-byte blocks from any
// source address into a wrapping destination window at DST_BASE. General
// mode moves all blocks in one burst; HBlank mode moves one block per
// hblank rising edge and releases the bus between blocks.
//   clk     CPU clock
//   rst     synchronous active-low reset
//   ct      machine-cycle phase; transfers start on ct == 2'b10
//   hblank  PPU HBlank level
//   bus     hdma_if.master: MMIO window and DMA master port
module hdma_engine #(
  parameter int              ADDR_W   = 16,
  parameter int              BLK_LOG2 = 4,
  parameter int              LEN_W    = 7,
  parameter logic [ADDR_W-1:0] DST_BASE = 16'h8000,
  parameter int              DST_W    = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ct,
  input  logic       hblank,
  hdma_if.master     bus
);
  import hdma_pkg::*;

  state_e              state;
  logic [ADDR_W-1:0]   src;
  logic [DST_W-1:0]    dst;
  logic [LEN_W-1:0]    len;
  logic [BLK_LOG2-1:0] blk_idx;
  logic                hmode;
  logic                cancel;
  logic                hb_rise;
  logic                ctrl_wr;
  logic                cancel_wr;
  logic                blk_end;

  edge_det u_hb_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (hblank),
    .rise (hb_rise)
  );

  assign ctrl_wr   = bus.mmio_wr && (bus.mmio_sel == REG_CTRL);
  // Only a mode-0 CTRL write during an HBlank-mode transfer cancels it.
  assign cancel_wr = ctrl_wr && (bus.mmio_din[7] == MODE_GENERAL) && hmode;
  assign blk_end   = &blk_idx;

  // NOTE: all engine state is one clocked block with non-blocking assignments,
  // so every register sees pre-edge values and simulation matches synthesis.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= IDLE;
      src                <= '0;
      dst                <= '0;
      len                <= '1;
      blk_idx            <= '0;
      hmode              <= MODE_GENERAL;
      cancel             <= 1'b0;
      bus.dma_rd         <= 1'b0;
      bus.dma_wr         <= 1'b0;
      bus.dma_a          <= '0;
      bus.dma_dout       <= '0;
      bus.dma_occupy_bus <= 1'b0;
    end else begin
      if (state != IDLE && state != HWAIT && cancel_wr) cancel <= 1'b1;

      unique case (state)
        IDLE: begin
          if (bus.mmio_wr) begin
            unique case (bus.mmio_sel)
              REG_SRC_HI: src[ADDR_W-1:8] <= (ADDR_W-8)'(bus.mmio_din);
              REG_SRC_LO: src[7:0] <= {bus.mmio_din[7:BLK_LOG2], {BLK_LOG2{1'b0}}};
              REG_DST_HI: dst[DST_W-1:8] <= (DST_W-8)'(bus.mmio_din);
              REG_DST_LO: dst[7:0] <= {bus.mmio_din[7:BLK_LOG2], {BLK_LOG2{1'b0}}};
              REG_CTRL: begin
                len     <= bus.mmio_din[LEN_W-1:0];
                hmode   <= bus.mmio_din[7];
                blk_idx <= '0;
                cancel  <= 1'b0;
                if (bus.mmio_din[7] == MODE_HBLANK) begin
                  state <= HWAIT;
                end else begin
                  state              <= ALIGN;
                  bus.dma_occupy_bus <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end

        HWAIT: begin
          if (cancel_wr) begin
            state <= IDLE;
          end else if (hb_rise) begin
            state              <= ALIGN;
            bus.dma_occupy_bus <= 1'b1;
          end
        end

        ALIGN: begin
          if (ct == 2'b10) begin
            state      <= RD_ADDR;
            bus.dma_rd <= 1'b1;
            bus.dma_a  <= src;
          end
        end

        RD_ADDR: state <= RD_DATA;

        RD_DATA: begin
          state        <= WR;
          bus.dma_dout <= bus.dma_din;
          bus.dma_rd   <= 1'b0;
          bus.dma_wr   <= 1'b1;
          bus.dma_a    <= DST_BASE | ADDR_W'(dst);
        end

        WR: state <= WR_WAIT;

        WR_WAIT: begin
          bus.dma_wr <= 1'b0;
          src        <= src + 1'b1;
          dst        <= dst + 1'b1;
          blk_idx    <= blk_idx + 1'b1;
          if (blk_end && len == '0) begin
            // Last block done: all-ones length marks completion.
            state              <= IDLE;
            len                <= '1;
            bus.dma_occupy_bus <= 1'b0;
          end else if (blk_end) begin
            // Block end takes priority over a same-cycle cancel: len is
            // still decremented before the engine stops.
            len <= len - 1'b1;
            if (cancel || cancel_wr) begin
              state              <= IDLE;
              bus.dma_occupy_bus <= 1'b0;
            end else if (hmode == MODE_HBLANK) begin
              state              <= HWAIT;
              bus.dma_occupy_bus <= 1'b0;
            end else begin
              state      <= RD_ADDR;
              bus.dma_rd <= 1'b1;
              bus.dma_a  <= src + 1'b1;
            end
          end else if (cancel || cancel_wr) begin
            state              <= IDLE;
            bus.dma_occupy_bus <= 1'b0;
          end else begin
            state      <= RD_ADDR;
            bus.dma_rd <= 1'b1;
            bus.dma_a  <= src + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: default assigned first so no path leaves mmio_dout unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    bus.mmio_dout = 8'hFF;
    if (bus.mmio_sel == REG_CTRL) bus.mmio_dout = {state == IDLE, 7'(len)};
  end

endmodule

// File: tb/tb_hdma_engine.sv
// tb_hdma_engine: directed, table-driven bench for hdma_engine. A memory
// model answers reads with a fixed function of the address; every write is
// logged and compared against the address/data the engine should produce.
module tb_hdma_engine;
  import hdma_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] ct = 2'd0;
  logic       hblank = 1'b0;
  int         cyc = 0;
  logic [1:0] ct_smp = 2'd0;

  int checks = 0;
  int errors = 0;

  hdma_if #(.ADDR_W(16)) bus ();

  hdma_engine #(
    .ADDR_W(16), .BLK_LOG2(4), .LEN_W(7), .DST_BASE(16'h8000), .DST_W(13)
  ) dut (
    .clk(clk), .rst(rst), .ct(ct), .hblank(hblank), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin #2 ct = ct + 2'd1; end
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ct_smp <= ct;

  function automatic logic [7:0] mem_data(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  // Source memory: data for the address presented while dma_rd is high.
  always @(negedge clk) begin
    if (!rst) bus.dma_din = 8'h00;
    else if (bus.dma_rd) bus.dma_din = mem_data(bus.dma_a);
  end

  // Bus monitor: logs write transactions, read starts and occupancy.
  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          edge_n;
  } wr_rec_t;

  wr_rec_t wq[$];
  int      rd_edges[$];
  int      occ_total = 0;
  int      rd_phase_bad = 0;
  logic    rd_q = 1'b0;
  logic    wr_q = 1'b0;

  always @(negedge clk) begin
    if (bus.dma_rd && !rd_q) begin
      rd_edges.push_back(cyc);
      if (ct_smp != 2'b10) rd_phase_bad++;
    end
    if (bus.dma_wr && !wr_q) wq.push_back('{bus.dma_a, bus.dma_dout, cyc});
    if (bus.dma_occupy_bus) occ_total++;
    rd_q = bus.dma_rd;
    wr_q = bus.dma_wr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic mmio_write(input logic [2:0] sel, input logic [7:0] din);
    tick();
    bus.mmio_sel = sel;
    bus.mmio_din = din;
    bus.mmio_wr  = 1'b1;
    tick();
    bus.mmio_wr  = 1'b0;
  endtask

  task automatic mmio_read(input logic [2:0] sel, output logic [7:0] data);
    tick();
    bus.mmio_sel = sel;
    #1 data = bus.mmio_dout;
  endtask

  // Issue a CTRL write whose active edge samples ct == ct_want; returns
  // the number of that edge.
  task automatic ctrl_at(input logic [7:0] din, input logic [1:0] ct_want, output int we);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ct == ct_want) break;
    end
    bus.mmio_sel = REG_CTRL;
    bus.mmio_din = din;
    bus.mmio_wr  = 1'b1;
    tick();
    bus.mmio_wr  = 1'b0;
    we = cyc;
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int n = 0;
    while (wq.size() < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(wq.size() >= target), 32'd1);
  endtask

  task automatic pulse_hblank(input int width);
    tick();
    hblank = 1'b1;
    repeat (width) tick();
    hblank = 1'b0;
  endtask

  task automatic set_regs(input logic [7:0] sh, sl, dh, dl);
    mmio_write(REG_SRC_HI, sh);
    mmio_write(REG_SRC_LO, sl);
    mmio_write(REG_DST_HI, dh);
    mmio_write(REG_DST_LO, dl);
  endtask

  // Compare n logged writes starting at base with the expected stream.
  task automatic check_stream(input string tag, input int base, input logic [15:0] src0,
                              input logic [12:0] dst0, input int n, input bit gapless);
    for (int k = 0; k < n; k++) begin
      logic [12:0] d;
      logic [15:0] s;
      d = dst0 + 13'(k);
      s = src0 + 16'(k);
      check({tag, "_addr"}, 32'(wq[base+k].a), 32'(16'h8000 | 16'(d)));
      check({tag, "_data"}, 32'(wq[base+k].d), 32'(mem_data(s)));
      if (gapless && k > 0)
        check({tag, "_gap"}, 32'(wq[base+k].edge_n - wq[base+k-1].edge_n), 32'd4);
    end
  endtask

  typedef struct {
    logic [2:0] sel;
    logic       wr;
    logic [7:0] din;
    logic [7:0] exp;
  } mmio_vec_t;

  typedef struct {
    string       tag;
    logic [7:0]  sh, sl, dh, dl, ctrl;
    logic [1:0]  ct_w;
    logic [15:0] src0;
    logic [12:0] dst0;
    int          n;
    int          delay;
  } gen_vec_t;

  task automatic run_gen(input gen_vec_t r);
    int base, occ0, rb, we;
    logic [7:0] rd;
    base = wq.size();
    occ0 = occ_total;
    rb   = rd_edges.size();
    set_regs(r.sh, r.sl, r.dh, r.dl);
    ctrl_at(r.ctrl, r.ct_w, we);
    wait_writes(base + r.n, r.n * 4 + 20, {r.tag, "_done"});
    repeat (6) tick();
    check({r.tag, "_count"}, 32'(wq.size() - base), 32'(r.n));
    if (rd_edges.size() > rb) check({r.tag, "_rd_delay"}, 32'(rd_edges[rb] - we), 32'(r.delay));
    else check({r.tag, "_rd_seen"}, 32'd0, 32'd1);
    check({r.tag, "_occupy"}, 32'(occ_total - occ0), 32'(r.delay + 4 * r.n));
    if (wq.size() >= base + r.n) check_stream(r.tag, base, r.src0, r.dst0, r.n, 1'b1);
    mmio_read(REG_CTRL, rd);
    check({r.tag, "_ctrl"}, 32'(rd), 32'hFF);
  endtask

  mmio_vec_t mv[9];
  gen_vec_t  gv[4];

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] rd;
    int base, occ0, we;

    mv[0] = '{REG_SRC_HI, 1'b0, 8'h00, 8'hFF};
    mv[1] = '{REG_SRC_LO, 1'b0, 8'h00, 8'hFF};
    mv[2] = '{REG_DST_HI, 1'b0, 8'h00, 8'hFF};
    mv[3] = '{REG_DST_LO, 1'b0, 8'h00, 8'hFF};
    mv[4] = '{REG_CTRL,   1'b0, 8'h00, 8'hFF};
    mv[5] = '{REG_SRC_HI, 1'b1, 8'h12, 8'hFF};
    mv[6] = '{REG_DST_LO, 1'b1, 8'h47, 8'hFF};
    mv[7] = '{3'd5,       1'b0, 8'h00, 8'hFF};
    mv[8] = '{3'd7,       1'b0, 8'h00, 8'hFF};

    // tag, SRC_HI, SRC_LO, DST_HI, DST_LO, CTRL, ct at write, src0, dst0, bytes, rd delay
    gv[0] = '{"gen_c000", 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd3, 16'hC000, 13'h0000, 16, 3};
    gv[1] = '{"gen_wrap", 8'hFF, 8'hF5, 8'h1F, 8'hF3, 8'h01, 2'd0, 16'hFFF0, 13'h1FF0, 32, 2};
    gv[2] = '{"gen_3blk", 8'h12, 8'h35, 8'h05, 8'h47, 8'h02, 2'd2, 16'h1230, 13'h0540, 48, 4};
    gv[3] = '{"restart",  8'h30, 8'h00, 8'h03, 8'h00, 8'h00, 2'd1, 16'h3000, 13'h0300, 16, 1};

    bus.mmio_sel = 3'd0;
    bus.mmio_wr  = 1'b0;
    bus.mmio_din = 8'h00;
    rst = 1'b0;
    repeat (3) tick();
    check("rst_rd", 32'(bus.dma_rd), 32'd0);
    check("rst_wr", 32'(bus.dma_wr), 32'd0);
    check("rst_a", 32'(bus.dma_a), 32'd0);
    check("rst_dout", 32'(bus.dma_dout), 32'd0);
    check("rst_occupy", 32'(bus.dma_occupy_bus), 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      if (mv[i].wr) mmio_write(mv[i].sel, mv[i].din);
      mmio_read(mv[i].sel, rd);
      check($sformatf("mmio_%0d", i), 32'(rd), 32'(mv[i].exp));
    end

    for (int i = 0; i < 3; i++) run_gen(gv[i]);
    // Explicit wrap points of the two-block transfer.
    check("wrap_dst_end", 32'(wq[16+15].a), 32'h9FFF);
    check("wrap_dst_start", 32'(wq[16+16].a), 32'h8000);
    check("wrap_src_zero", 32'(wq[16+16].d), 32'(mem_data(16'h0000)));

    // HBlank mode, two blocks; a mid-block hblank edge must not queue.
    base = wq.size();
    occ0 = occ_total;
    set_regs(8'h40, 8'h00, 8'h01, 8'h00);
    mmio_write(REG_CTRL, 8'h81);
    repeat (20) tick();
    check("hb_no_writes", 32'(wq.size() - base), 32'd0);
    check("hb_no_occupy", 32'(occ_total - occ0), 32'd0);
    mmio_read(REG_CTRL, rd);
    check("hb_ctrl_armed", 32'(rd), 32'h01);
    pulse_hblank(3);
    repeat (20) tick();
    pulse_hblank(1);
    wait_writes(base + 16, 100, "hb_blk1");
    repeat (30) tick();
    check("hb_blk1_count", 32'(wq.size() - base), 32'd16);
    mmio_read(REG_CTRL, rd);
    check("hb_ctrl_between", 32'(rd), 32'h00);
    check("hb_occupy_between", 32'(bus.dma_occupy_bus), 32'd0);
    mmio_write(REG_SRC_HI, 8'h77);
    pulse_hblank(2);
    wait_writes(base + 32, 100, "hb_blk2");
    repeat (10) tick();
    check("hb_blk2_count", 32'(wq.size() - base), 32'd32);
    mmio_read(REG_CTRL, rd);
    check("hb_ctrl_done", 32'(rd), 32'hFF);
    if (wq.size() >= base + 32) check_stream("hb", base, 16'h4000, 13'h0100, 32, 1'b0);

    // Cancel in HWAIT after one of four blocks.
    base = wq.size();
    set_regs(8'h20, 8'h00, 8'h02, 8'h00);
    mmio_write(REG_CTRL, 8'h83);
    pulse_hblank(2);
    wait_writes(base + 16, 100, "cancel_blk1");
    repeat (10) tick();
    mmio_write(REG_CTRL, 8'h00);
    mmio_read(REG_CTRL, rd);
    check("cancel_ctrl", 32'(rd), 32'h82);
    pulse_hblank(2);
    repeat (100) tick();
    check("cancel_count", 32'(wq.size() - base), 32'd16);
    check("cancel_occupy", 32'(bus.dma_occupy_bus), 32'd0);

    // Reset during byte 7 of a general transfer.
    base = wq.size();
    set_regs(8'h30, 8'h00, 8'h03, 8'h00);
    ctrl_at(8'h00, 2'd0, we);
    wait_writes(base + 7, 60, "rst_mid_progress");
    repeat (2) tick();
    check("pre_rst_rd", 32'(bus.dma_rd), 32'd1);
    rst = 1'b0;
    tick();
    check("mid_rst_rd", 32'(bus.dma_rd), 32'd0);
    check("mid_rst_wr", 32'(bus.dma_wr), 32'd0);
    check("mid_rst_occupy", 32'(bus.dma_occupy_bus), 32'd0);
    check("mid_rst_a", 32'(bus.dma_a), 32'd0);
    rst = 1'b1;
    mmio_read(REG_CTRL, rd);
    check("mid_rst_ctrl", 32'(rd), 32'hFF);
    run_gen(gv[3]);

    check("rd_phase_bad", 32'(rd_phase_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
